// File: rtl/subterranean_duplex_feeder_if.sv
// Bundle of the feeder's non-clock signals: message control, the 32-bit word
// stream in, the 4-lane block interface to the Subterranean duplex core, and
// the result stream out.
//
// Handshakes: a word moves when s_valid && s_ready on a rising clk edge, and a
// result moves when r_valid && r_ready. A sender must not withdraw or change a
// payload while valid is high and ready is low. ready may depend on state only,
// never on valid.
//
// modport slave  : the feeder itself
// modport master : the environment (word source, duplex core, result sink)
interface subterranean_duplex_feeder_if;
    logic         msg_init;
    logic         init_ready;
    logic [1:0]   mode;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [2:0]   s_bytes;
    logic         s_last;
    logic         core_init;
    logic         core_start;
    logic         core_encrypt;
    logic         core_decrypt;
    logic [1:0]   core_enable_round;
    logic [127:0] core_din;
    logic [11:0]  core_din_size;
    logic [127:0] core_dout;
    logic         r_valid;
    logic         r_ready;
    logic [127:0] r_data;
    logic [11:0]  r_size;
    logic         r_last;

    modport slave (
        input  msg_init, mode, s_valid, s_data, s_bytes, s_last, core_dout, r_ready,
        output init_ready, s_ready, core_init, core_start, core_encrypt, core_decrypt,
               core_enable_round, core_din, core_din_size, r_valid, r_data, r_size, r_last
    );

    modport master (
        output msg_init, mode, s_valid, s_data, s_bytes, s_last, core_dout, r_ready,
        input  init_ready, s_ready, core_init, core_start, core_encrypt, core_decrypt,
               core_enable_round, core_din, core_din_size, r_valid, r_data, r_size, r_last
    );
endinterface

// File: rtl/subterranean_duplex_feeder.sv
// Upstream feeder for the 4-round Subterranean duplex core.
// Packs up to four 32-bit words into a 128-bit block, issues the block to the
// core with a one-cycle start pulse, and registers the core's combinational
// output as a result handed downstream with valid/ready. A message that ends
// in a full 4-byte word gets an extra empty lane (or, if the block is already
// full, an extra block holding a single empty lane).
//
// Ports:
//   clk       clock
//   arstn     asynchronous active-low reset
//   bus       slave side of subterranean_duplex_feeder_if (stream, core, result)
//   dbg_state current FSM state, 0 = FILL, 1 = ISSUE
module subterranean_duplex_feeder (
    input  logic                          clk,
    input  logic                          arstn,
    subterranean_duplex_feeder_if.slave   bus,
    output logic                          dbg_state
);
    typedef enum logic {FILL = 1'b0, ISSUE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          pad_q, pad_d;
    logic          rlp_q, rlp_d;       // r_last for the block being built
    logic [1:0]    mode_q, mode_d;
    logic [31:0]   lane_data_q [4];
    logic [31:0]   lane_data_d [4];
    logic [2:0]    lane_size_q [4];
    logic [2:0]    lane_size_d [4];
    logic          r_valid_q, r_valid_d;
    logic [127:0]  r_data_q, r_data_d;
    logic [11:0]   r_size_q, r_size_d;
    logic          r_last_q, r_last_d;

    logic          accept;
    logic          fire;
    logic          full_end;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic [2:0]    cnt_m1;

    assign bus.s_ready    = (state_q == FILL) && !pad_q;
    assign bus.init_ready = (state_q == FILL) && (cnt_q == 3'd0) && !pad_q;
    assign bus.core_init  = bus.msg_init && bus.init_ready;

    assign accept   = bus.s_valid && bus.s_ready;
    // Issue only when the result register is free or is being drained now.
    assign fire     = (state_q == ISSUE) && (!r_valid_q || bus.r_ready);
    assign full_end = bus.s_last && (bus.s_bytes == 3'd4);
    assign idx      = cnt_q[1:0];
    assign idx_nxt  = idx + 2'd1;
    assign cnt_m1   = cnt_q - 3'd1;

    assign bus.core_start        = fire;
    assign bus.core_encrypt      = (mode_q == 2'b01);
    assign bus.core_decrypt      = (mode_q == 2'b10);
    // cnt==0 only when no block is held; report 0 rather than a wrapped 3.
    assign bus.core_enable_round = (cnt_q == 3'd0) ? 2'd0 : cnt_m1[1:0];

    for (genvar i = 0; i < 4; i++) begin : g_lanes
        assign bus.core_din[32*i +: 32]     = lane_data_q[i];
        assign bus.core_din_size[3*i +: 3]  = lane_size_q[i];
    end

    assign bus.r_valid = r_valid_q;
    assign bus.r_data  = r_data_q;
    assign bus.r_size  = r_size_q;
    assign bus.r_last  = r_last_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pad_d       = pad_q;
        rlp_d       = rlp_q;
        mode_d      = mode_q;
        lane_data_d = lane_data_q;
        lane_size_d = lane_size_q;
        r_valid_d   = r_valid_q && !bus.r_ready;
        r_data_d    = r_data_q;
        r_size_d    = r_size_q;
        r_last_d    = r_last_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (cnt_q == 3'd0) begin
                        mode_d = bus.mode;
                    end
                    lane_data_d[idx] = bus.s_data;
                    lane_size_d[idx] = bus.s_bytes;
                    cnt_d = cnt_q + 3'd1;
                    if (full_end && (idx != 2'd3)) begin
                        // Room left: the empty terminating lane joins this block.
                        lane_data_d[idx_nxt] = 32'd0;
                        lane_size_d[idx_nxt] = 3'd0;
                        cnt_d = cnt_q + 3'd2;
                    end
                    if (full_end && (idx == 2'd3)) begin
                        pad_d = 1'b1;
                    end
                    if ((idx == 2'd3) || bus.s_last) begin
                        state_d = ISSUE;
                        // A block that spills its terminator into a pad block
                        // does not close the message itself.
                        rlp_d = bus.s_last && !(full_end && (idx == 2'd3));
                    end
                end
            end
            ISSUE: begin
                if (fire) begin
                    r_valid_d = 1'b1;
                    r_data_d  = bus.core_dout;
                    r_size_d  = bus.core_din_size;
                    r_last_d  = rlp_q;
                    for (int i = 0; i < 4; i++) begin
                        lane_data_d[i] = 32'd0;
                        lane_size_d[i] = 3'd0;
                    end
                    cnt_d   = 3'd0;
                    state_d = FILL;
                    if (pad_q) begin
                        // Single empty lane block closing the message.
                        cnt_d   = 3'd1;
                        rlp_d   = 1'b1;
                        pad_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= FILL;
            cnt_q     <= 3'd0;
            pad_q     <= 1'b0;
            rlp_q     <= 1'b0;
            mode_q    <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                lane_data_q[i] <= 32'd0;
                lane_size_q[i] <= 3'd0;
            end
            r_valid_q <= 1'b0;
            r_data_q  <= 128'd0;
            r_size_q  <= 12'd0;
            r_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pad_q       <= pad_d;
            rlp_q       <= rlp_d;
            mode_q      <= mode_d;
            lane_data_q <= lane_data_d;
            lane_size_q <= lane_size_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            r_size_q    <= r_size_d;
            r_last_q    <= r_last_d;
        end
    end
endmodule

// File: tb/tb_subterranean_duplex_feeder.sv
// Directed bench for subterranean_duplex_feeder: a table of whole-message
// vectors with hand-computed block descriptors, plus hand-written sequences
// for result backpressure, msg_init gating and mid-fill reset.
module tb_subterranean_duplex_feeder;
    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic dbg_state;

    always #5 clk = ~clk;

    subterranean_duplex_feeder_if bus();

    localparam logic [127:0] KEY = 128'h5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_9696_6969;

    // Stand-in for the duplex core: a fixed combinational scramble of din.
    assign bus.core_dout = bus.core_din ^ KEY;

    subterranean_duplex_feeder dut (
        .clk       (clk),
        .arstn     (arstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    typedef struct packed {
        logic [2:0]       nwords;
        logic [3:0][31:0] data;
        logic [3:0][2:0]  bytes;
        logic             last;
        logic [1:0]       mode0;
        logic [1:0]       mode_rest;
        logic [1:0]       exp_en;
        logic [11:0]      exp_size;
        logic             exp_enc;
        logic             exp_dec;
        logic             exp_rlast;
        logic             exp_pad;
    } vec_t;

    vec_t vecs [7];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [2:0] b0, input logic [2:0] b1,
                                input logic [2:0] b2, input logic [2:0] b3,
                                input logic last, input logic [1:0] m0, input logic [1:0] mr,
                                input logic [1:0] en, input logic [11:0] sz,
                                input logic enc, input logic dec,
                                input logic rlast, input logic pad);
        vec_t v;
        v.nwords = n;
        v.data = {d3, d2, d1, d0};
        v.bytes = {b3, b2, b1, b0};
        v.last = last; v.mode0 = m0; v.mode_rest = mr;
        v.exp_en = en; v.exp_size = sz; v.exp_enc = enc; v.exp_dec = dec;
        v.exp_rlast = rlast; v.exp_pad = pad;
        return v;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic feed(input logic [31:0] d, input logic [2:0] b, input logic l, input logic [1:0] m);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_bytes = b;
        bus.s_last  = l;
        bus.mode    = m;
        #1;
        check("s_ready_on_feed", bus.s_ready, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    initial begin
        logic [127:0] exp_din;
        int starts;

        bus.msg_init = 1'b0; bus.mode = 2'b00; bus.s_valid = 1'b0;
        bus.s_data = 32'd0; bus.s_bytes = 3'd0; bus.s_last = 1'b0; bus.r_ready = 1'b1;

        vecs[0] = mk(3'd4, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                     3'd4, 3'd4, 3'd4, 3'd4, 1'b0, 2'b01, 2'b10,
                     2'd3, 12'h924, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(3'd1, 32'h0000BBAA, 32'd0, 32'd0, 32'd0,
                     3'd2, 3'd0, 3'd0, 3'd0, 1'b1, 2'b10, 2'b10,
                     2'd0, 12'h002, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[2] = mk(3'd2, 32'h11223344, 32'h55667788, 32'd0, 32'd0,
                     3'd4, 3'd4, 3'd0, 3'd0, 1'b1, 2'b00, 2'b00,
                     2'd2, 12'h024, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[3] = mk(3'd4, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004,
                     3'd4, 3'd4, 3'd4, 3'd4, 1'b1, 2'b01, 2'b01,
                     2'd3, 12'h924, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[4] = mk(3'd3, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'h000000C1, 32'd0,
                     3'd4, 3'd4, 3'd1, 3'd0, 1'b1, 2'b11, 2'b01,
                     2'd2, 12'h064, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5] = mk(3'd1, 32'h00000000, 32'd0, 32'd0, 32'd0,
                     3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 2'b01, 2'b01,
                     2'd0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[6] = mk(3'd3, 32'hCAFE0000, 32'hCAFE1111, 32'hCAFE2222, 32'd0,
                     3'd4, 3'd4, 3'd4, 3'd0, 1'b1, 2'b10, 2'b00,
                     2'd3, 12'h124, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_r_data", bus.r_data, 0);
        check("rst_core_din", bus.core_din, 0);
        check("rst_core_en", bus.core_enable_round, 0);
        check("rst_core_size", bus.core_din_size, 0);
        check("rst_core_start", bus.core_start, 0);
        check("rst_core_enc", {bus.core_encrypt, bus.core_decrypt}, 0);
        check("rst_init_ready", bus.init_ready, 1);
        @(negedge clk);
        arstn = 1'b1;

        // Table-driven whole-message vectors
        for (int r = 0; r < 7; r++) begin
            exp_din = '0;
            for (int i = 0; i < 4; i++)
                if (i < int'(vecs[r].nwords)) exp_din[32*i +: 32] = vecs[r].data[i];
            for (int i = 0; i < int'(vecs[r].nwords); i++)
                feed(vecs[r].data[i], vecs[r].bytes[i],
                     vecs[r].last && (i == int'(vecs[r].nwords) - 1),
                     (i == 0) ? vecs[r].mode0 : vecs[r].mode_rest);
            idle_inputs();
            bus.mode = ~vecs[r].mode0;
            #1;
            check($sformatf("v%0d_start", r), bus.core_start, 1);
            check($sformatf("v%0d_en", r), bus.core_enable_round, vecs[r].exp_en);
            check($sformatf("v%0d_size", r), bus.core_din_size, vecs[r].exp_size);
            check($sformatf("v%0d_din", r), bus.core_din, exp_din);
            check($sformatf("v%0d_encdec", r), {bus.core_encrypt, bus.core_decrypt},
                  {vecs[r].exp_enc, vecs[r].exp_dec});
            check($sformatf("v%0d_s_ready_issue", r), bus.s_ready, 0);
            @(negedge clk); #1;
            check($sformatf("v%0d_r_valid", r), bus.r_valid, 1);
            check($sformatf("v%0d_r_data", r), bus.r_data, exp_din ^ KEY);
            check($sformatf("v%0d_r_size", r), bus.r_size, vecs[r].exp_size);
            check($sformatf("v%0d_r_last", r), bus.r_last, vecs[r].exp_rlast);
            if (vecs[r].exp_pad) begin
                check($sformatf("v%0d_pad_start", r), bus.core_start, 1);
                check($sformatf("v%0d_pad_en", r), bus.core_enable_round, 0);
                check($sformatf("v%0d_pad_size", r), bus.core_din_size, 0);
                check($sformatf("v%0d_pad_din", r), bus.core_din, 0);
                @(negedge clk); #1;
                check($sformatf("v%0d_pad_r_valid", r), bus.r_valid, 1);
                check($sformatf("v%0d_pad_r_last", r), bus.r_last, 1);
                check($sformatf("v%0d_pad_r_size", r), bus.r_size, 0);
                check($sformatf("v%0d_pad_r_data", r), bus.r_data, KEY);
            end else begin
                check($sformatf("v%0d_no_extra_start", r), bus.core_start, 0);
            end
            @(negedge clk); #1;
            check($sformatf("v%0d_r_drained", r), bus.r_valid, 0);
        end

        // Backpressure: result held, next block stalls in ISSUE
        bus.r_ready = 1'b0;
        feed(32'h0000AA55, 3'd2, 1'b1, 2'b00);
        idle_inputs();
        #1;
        check("bp_first_start", bus.core_start, 1);
        @(negedge clk);
        feed(32'h00C0FFEE, 3'd3, 1'b1, 2'b00);
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("bp_stall_start", bus.core_start, 0);
            check("bp_stall_s_ready", bus.s_ready, 0);
            check("bp_stall_state", dbg_state, 1);
            check("bp_stall_r_data", bus.r_data, {96'd0, 32'h0000AA55} ^ KEY);
            @(negedge clk);
        end
        bus.r_ready = 1'b1;
        #1;
        check("bp_release_start", bus.core_start, 1);
        @(negedge clk); #1;
        check("bp_new_r_valid", bus.r_valid, 1);
        check("bp_new_r_data", bus.r_data, {96'd0, 32'h00C0FFEE} ^ KEY);
        check("bp_new_r_size", bus.r_size, 12'h003);
        check("bp_new_r_last", bus.r_last, 1);
        @(negedge clk); #1;
        check("bp_drained", bus.r_valid, 0);

        // msg_init gating
        feed(32'h1, 3'd4, 1'b0, 2'b00);
        feed(32'h2, 3'd4, 1'b0, 2'b00);
        idle_inputs();
        bus.msg_init = 1'b1;
        #1;
        check("init_mid_block_core_init", bus.core_init, 0);
        check("init_mid_block_ready", bus.init_ready, 0);
        bus.msg_init = 1'b0;
        feed(32'h3, 3'd4, 1'b0, 2'b00);
        feed(32'h4, 3'd4, 1'b0, 2'b00);
        idle_inputs();
        @(negedge clk);
        bus.msg_init = 1'b1;
        #1;
        check("init_idle_core_init", bus.core_init, 1);
        check("init_idle_ready", bus.init_ready, 1);
        @(negedge clk);
        bus.msg_init = 1'b0;
        #1;
        check("init_released", bus.core_init, 0);

        // Reset mid-fill with a pending result
        bus.r_ready = 1'b0;
        feed(32'h77, 3'd1, 1'b1, 2'b01);
        idle_inputs();
        @(negedge clk); #1;
        check("rst2_pre_valid", bus.r_valid, 1);
        feed(32'h88, 3'd4, 1'b0, 2'b01);
        feed(32'h99, 3'd4, 1'b0, 2'b01);
        idle_inputs();
        arstn = 1'b0;
        #1;
        check("rst2_r_valid", bus.r_valid, 0);
        check("rst2_r_data", bus.r_data, 0);
        check("rst2_core_din", bus.core_din, 0);
        check("rst2_core_en", bus.core_enable_round, 0);
        check("rst2_core_enc", bus.core_encrypt, 0);
        check("rst2_init_ready", bus.init_ready, 1);
        @(negedge clk);
        arstn = 1'b1;
        bus.r_ready = 1'b1;
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (bus.core_start) starts++;
            @(negedge clk);
        end
        check("rst2_no_spurious_start", starts, 0);
        check("rst2_state_fill", dbg_state, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/subterranean_duplex_feeder.md
Name: subterranean_duplex_feeder

Overview:
- Upstream feeder for the 4-round Subterranean duplex core.
- Accepts a 32-bit word stream with per-word byte counts and last flags, and packs up to 4 words into one 128-bit block.
- Issues each block to the core with a one-cycle start pulse, correct enable_round and per-lane din_size, and inserts the empty padding lane that full-word message ends require.
- Captures the core's combinational dout during the issue cycle into a result register, handed downstream with valid/ready.

Parameters:
- None. Lane count is fixed at 4, lane width at 32 bits.

Ports:
- clk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- msg_init  in  1  request to zero the core state for a new message
- init_ready  out  1  msg_init is honoured this cycle
- mode  in  2  00 absorb, 01 encrypt, 10 decrypt; 11 treated as absorb
- s_valid  in  1  input word valid
- s_ready  out  1  input word accepted when s_valid&s_ready
- s_data  in  32  input word, byte 0 in [7:0]
- s_bytes  in  3  valid bytes 0..4; 0 is legal only with s_last
- s_last  in  1  final word of the message
- core_init  out  1  to core init
- core_start  out  1  to core start
- core_encrypt  out  1  to core encrypt
- core_decrypt  out  1  to core decrypt
- core_enable_round  out  2  number of used lanes minus 1
- core_din  out  128  lane i in [32i+31:32i]
- core_din_size  out  12  lane i byte count in [3i+2:3i]
- core_dout  in  128  core combinational output
- r_valid  out  1  result block valid
- r_ready  in  1  result consumed when r_valid&r_ready
- r_data  out  128  captured core_dout
- r_size  out  12  din_size of the captured block
- r_last  out  1  block closed a message

Behaviour:
- States: FILL, ISSUE.
- Reset values: state=FILL, cnt=0, pad_pending=0, all lane data 0, all lane sizes 0, held mode=00, r_valid=0, r_data=0, r_size=0, r_last=0, every core_* output 0.
- s_ready = (state==FILL) && !pad_pending.
- init_ready = (state==FILL) && cnt==0 && !pad_pending.
- core_init = msg_init & init_ready (combinational). msg_init at any other time is ignored.
- Word acceptance in FILL:
  - s_data and s_bytes are written into lane cnt, then cnt increments.
  - mode is sampled when cnt==0; a mode change mid-block is ignored.
- Block close conditions (evaluated in the acceptance cycle):
  - a) cnt reaches 4.
  - b) s_last=1.
  - On close: next state=ISSUE, r_last_pending=s_last.
- Padding rule: when s_last=1 and s_bytes==4:
  - If the accepted lane index < 3, the next lane gets size 0, data 0, and cnt increments again in the same cycle.
  - If the accepted lane was 3, set pad_pending.
- Unused lanes: data 0, size 0.
- core_din, core_din_size and core_enable_round=cnt-1 are driven from registers at all times.
- core_encrypt = (held mode==01); core_decrypt = (held mode==10).
- ISSUE cycle:
  - If !r_valid || r_ready: core_start=1 for exactly that cycle. Load r_data=core_dout, r_size=core_din_size, r_last=r_last_pending; set r_valid. Clear lanes, cnt=0.
  - Otherwise remain in ISSUE with core_start=0; all outputs are held.
- Padding block after ISSUE with pad_pending=1:
  - Build lane0 size 0, data 0, cnt=1, r_last_pending=1. Clear pad_pending; the next state is ISSUE again.
  - The earlier block that triggered pad_pending issues with r_last=0.
- Otherwise ISSUE returns to FILL.
- r_valid clears on r_ready unless a new ISSUE loads in the same cycle; a new load takes priority.
- Latency: last accepted word at cycle T → core_start at T+1 → r_valid at T+2. Sustained throughput is one block per (words+1) cycles.
- arstn deasserted mid-operation discards the partial block, pad_pending and any pending result. No core_start is generated until new input arrives.

Test Plan:
- Reset, then 4 full words 0x03020100..0x0F0E0D0C with mode=01 and no s_last → one core_start; core_enable_round=3, core_din_size=0x924; r_valid 2 cycles after the 4th accept with r_last=0.
- Message of a single word, 2 bytes, s_last, mode=10 → core_enable_round=0, core_din_size=0x002, core_decrypt=1 in the start cycle, r_last=1.
- Message ending with a full word in lane 1 (words of 4,4 bytes, last) → one block, core_enable_round=2, core_din_size=0x024, r_last=1.
- Message of 4 full words with last on the 4th → first block core_din_size=0x924 with r_last=0; then a second core_start with enable_round=0, din_size=0x000, r_last=1.
- Hold r_ready=0 with r_valid=1 and complete another block → FILL stalls in ISSUE, core_start stays 0 and s_ready stays 0. Raise r_ready → core_start in that same cycle and r_data updates the next cycle.
- msg_init pulsed with cnt=2 → core_init=0. Pulsed at cnt==0 in FILL → core_init=1 for that cycle; arstn pulse mid-fill → cnt=0 and no spurious core_start.
